nibble_serial_adder_ctrl: RTL

- Sequencer that time-shares one 4-bit ripple-carry slice to add or subtract WIDTH-bit operands, one nibble per clock, LSB nibble first.
- The carry is held in a register between nibbles.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Replaces a full-width adder when area matters more than latency.

---
 rtl/nibble_serial_adder_ctrl_pkg.sv | 26 ++
 rtl/nibble_serial_adder_ctrl_nibble_adder.sv | 25 ++
 rtl/nibble_serial_adder_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller.
//   state_t : controller state encoding (2-bit, encoding 3 unused/illegal)
//   OP_*    : operation select encoding on the op input
//   clog2   : ceiling log2, never less than 1 (sizes the nibble counter)
package nibble_serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Minimum of 1 so a single-nibble build still has a real counter bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_nibble_adder.sv
// nibble_adder: combinational 4-bit ripple-carry slice.
//   a, b : 4-bit addends
//   cin  : carry into bit 0
//   s    : 4-bit sum
//   cout : carry out of bit 3
module nibble_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: adds/subtracts WIDTH-bit operands through one
// shared 4-bit slice, one nibble per clock, LSB nibble first.
//   clk, rst_n              : clock, async active-low reset
//   start_valid/start_ready : operation handshake (ready only in IDLE)
//   a, b, c_in, op          : operands, add carry-in, 0=add 1=subtract
//   res_valid/res_ready     : result handshake (valid only in DONE)
//   sum, c_out, ovf         : result, carry out of MSB, signed overflow
//   busy                    : operation in flight or result pending
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             op,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CW      = clog2(NIBBLES);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    state_t st, st_nxt;

    logic [CW-1:0]             cnt;
    logic [NIBBLES-1:0][3:0]   a_q, b_q, sum_q;
    logic                      carry_q, c_out_q, ovf_q;
    logic                      accept, last;
    logic [3:0]                sl_s;
    logic                      sl_co;

    assign accept = start_valid && (st == ST_IDLE);
    assign last   = (cnt == LAST);

    // The single shared slice; the counter selects which nibble feeds it.
    nibble_adder u_slice (
        .a    (a_q[cnt]),
        .b    (b_q[cnt]),
        .cin  (carry_q),
        .s    (sl_s),
        .cout (sl_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= ST_IDLE;
        else        st <= st_nxt;
    end

    always_comb begin
        st_nxt      = st;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b0;
        case (st)
            ST_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) st_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last) st_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) st_nxt = ST_IDLE;
            end
            default: st_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            // Subtract is a + ~b + 1: invert B here and seed the carry with 1,
            // so RUN is identical for both operations.
            a_q     <= a;
            b_q     <= (op == OP_SUB) ? ~b : b;
            carry_q <= (op == OP_SUB) ? 1'b1 : c_in;
            cnt     <= '0;
        end else if (st == ST_RUN) begin
            sum_q[cnt] <= sl_s;
            carry_q    <= sl_co;
            if (last) begin
                c_out_q <= sl_co;
                // Same-sign operands producing an opposite-sign result.
                ovf_q   <= (a_q[NIBBLES-1][3] == b_q[NIBBLES-1][3]) &&
                           (sl_s[3] != a_q[NIBBLES-1][3]);
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule
